// File: rtl/wb_trace_if.sv
// Bundle for the commit-trace buffer: writeback debug capture inputs and the
// outbound trace stream.
//   debug_wb_pc/rf_wen/rf_wnum/rf_wdata : commit observed from the core writeback
//   trace_valid/trace_ready              : stream handshake
//   trace_seq/pc/wen/wnum/wdata          : head entry presented to the consumer
// Modports: master = core/consumer side (drives commits and ready),
//           slave  = buffer side (wb_trace_fifo).
interface wb_trace_if #(
  parameter int unsigned SEQ_W = 16
) ();
  logic [31:0]      debug_wb_pc;
  logic [3:0]       debug_wb_rf_wen;
  logic [4:0]       debug_wb_rf_wnum;
  logic [31:0]      debug_wb_rf_wdata;
  logic             trace_valid;
  logic             trace_ready;
  logic [SEQ_W-1:0] trace_seq;
  logic [31:0]      trace_pc;
  logic [3:0]       trace_wen;
  logic [4:0]       trace_wnum;
  logic [31:0]      trace_wdata;

  modport master (
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, trace_ready,
    input  trace_valid, trace_seq, trace_pc, trace_wen, trace_wnum, trace_wdata
  );

  modport slave (
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, trace_ready,
    output trace_valid, trace_seq, trace_pc, trace_wen, trace_wnum, trace_wdata
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// Commit-trace buffer. Captures every register-file writeback as a sequence-tagged
// entry in a circular first-word-fall-through FIFO and drains it over valid/ready.
// Dropped commits still consume a sequence number, so losses show as gaps.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous flush of FIFO, sequence counter and loss flags
//   tif        : wb_trace_if.slave (commit capture in, trace stream out)
//   level      : occupancy 0..DEPTH
//   ovf        : sticky, at least one commit dropped
//   drop_cnt   : dropped commits, saturating
module wb_trace_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter bit          DROP_R0 = 1'b1,
  parameter int unsigned SEQ_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  wb_trace_if.slave   tif,
  output logic [AW:0] level,
  output logic        ovf,
  output logic [15:0] drop_cnt
);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      pc;
    logic [3:0]       wen;
    logic [4:0]       wnum;
    logic [31:0]      wdata;
  } entry_t;

  localparam logic [AW:0] FullLvl = (AW+1)'(DEPTH);

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic [SEQ_W-1:0] seq_q;
  logic             ovf_q;
  logic [15:0]      drop_cnt_q;
  logic             cap, full, pop, push, drop, valid;

  always_comb begin
    cap   = (|tif.debug_wb_rf_wen) && !(DROP_R0 && (tif.debug_wb_rf_wnum == 5'd0));
    valid = (level_q != '0);
    full  = (level_q == FullLvl);
    pop   = valid && tif.trace_ready;
    // A full FIFO still accepts a commit when the head leaves in the same cycle.
    push  = cap && (!full || pop);
    drop  = cap && full && !pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      seq_q      <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      seq_q      <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      // Pointers wrap naturally at DEPTH (power of two); full/empty come from level.
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
      // Every capture consumes a tag, including dropped ones.
      if (cap) seq_q <= seq_q + SEQ_W'(1);
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr_q] <= '{seq:   seq_q,
                         pc:    tif.debug_wb_pc,
                         wen:   tif.debug_wb_rf_wen,
                         wnum:  tif.debug_wb_rf_wnum,
                         wdata: tif.debug_wb_rf_wdata};
    end
  end

  always_comb begin
    head            = valid ? mem[rd_ptr_q] : '0;
    tif.trace_valid = valid;
    tif.trace_seq   = head.seq;
    tif.trace_pc    = head.pc;
    tif.trace_wen   = head.wen;
    tif.trace_wnum  = head.wnum;
    tif.trace_wdata = head.wdata;
    level           = level_q;
    ovf             = ovf_q;
    drop_cnt        = drop_cnt_q;
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
module tb_wb_trace_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [4:0]  level;
  logic        ovf;
  logic [15:0] drop_cnt;
  int          checks = 0;
  int          errors = 0;

  wb_trace_if #(.SEQ_W(16)) tif ();

  wb_trace_fifo #(.DEPTH(16), .AW(4), .DROP_R0(1'b1), .SEQ_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .tif      (tif),
    .level    (level),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] seq;
    logic [31:0] pc;
    logic [31:0] wdata;
  } ent_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [3:0] wen, input logic [4:0] wnum,
                        input logic [31:0] wdata);
    tif.debug_wb_pc       = pc;
    tif.debug_wb_rf_wen   = wen;
    tif.debug_wb_rf_wnum  = wnum;
    tif.debug_wb_rf_wdata = wdata;
  endtask

  task automatic idle();
    commit(32'h0, 4'h0, 5'd0, 32'h0);
  endtask

  task automatic flush();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    ent_t        q[$];
    ent_t        prev;
    logic        stall;
    logic        r;
    logic        c;
    logic [15:0] seq_exp;
    int          n;
    int          cyc;

    idle();
    tif.trace_ready = 1'b1;
    #2;
    check("rst_valid", tif.trace_valid, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_seq", tif.trace_seq, 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: three commits back to back, consumer always ready
    for (int i = 0; i < 3; i++) begin
      commit(32'hBFC00000 + 32'(4 * i), 4'hF, 5'(i + 1), 32'h1000 + 32'(i));
      tick();
      check("t1_valid", tif.trace_valid, 1);
      check("t1_seq", tif.trace_seq, 64'(i));
      check("t1_pc", tif.trace_pc, 32'hBFC00000 + 32'(4 * i));
      check("t1_wnum", tif.trace_wnum, 64'(i + 1));
      check("t1_wdata", tif.trace_wdata, 32'h1000 + 32'(i));
      check("t1_wen", tif.trace_wen, 4'hF);
    end
    idle();
    tick();
    check("t1_empty", tif.trace_valid, 0);
    check("t1_zero_pc", tif.trace_pc, 0);

    // 2: r0 write and wen=0 are not captured and consume no tag
    flush();
    commit(32'h100, 4'hF, 5'd0, 32'hDEAD);
    tick();
    check("t2_r0_valid", tif.trace_valid, 0);
    commit(32'h104, 4'h0, 5'd5, 32'hBEEF);
    tick();
    check("t2_nowen_valid", tif.trace_valid, 0);
    check("t2_level", level, 0);
    commit(32'h108, 4'h3, 5'd7, 32'h55);
    tick();
    check("t2_valid", tif.trace_valid, 1);
    check("t2_seq", tif.trace_seq, 0);
    check("t2_wen", tif.trace_wen, 4'h3);
    idle();
    tick();

    // 3: overflow with consumer stalled
    flush();
    tif.trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      commit(32'(4 * i), 4'hF, 5'((i % 31) + 1), 32'(i));
      tick();
    end
    idle();
    check("t3_level", level, 16);
    check("t3_ovf", ovf, 1);
    check("t3_drop", drop_cnt, 4);
    tif.trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t3_drain_seq", tif.trace_seq, 64'(i));
      check("t3_drain_wnum", tif.trace_wnum, 64'((i % 31) + 1));
      tick();
    end
    check("t3_drained", tif.trace_valid, 0);
    tif.trace_ready = 1'b0;
    commit(32'h200, 4'hF, 5'd3, 32'h20);
    tick();
    idle();
    check("t3_next_seq", tif.trace_seq, 20);
    check("t3_next_level", level, 1);

    // 4: full FIFO, commit and pop in the same cycle
    for (int i = 21; i < 36; i++) begin
      commit(32'h300 + 32'(i), 4'hF, 5'd4, 32'(i));
      tick();
    end
    check("t4_full", level, 16);
    check("t4_drop_pre", drop_cnt, 4);
    commit(32'hCAFE0000, 4'hF, 5'd9, 32'h99);
    tif.trace_ready = 1'b1;
    tick();
    tif.trace_ready = 1'b0;
    idle();
    check("t4_level", level, 16);
    check("t4_drop", drop_cnt, 4);
    check("t4_head_seq", tif.trace_seq, 21);
    tif.trace_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("t4_drain_seq", tif.trace_seq, 64'(21 + k));
      if (k == 15) check("t4_tail_pc", tif.trace_pc, 32'hCAFE0000);
      tick();
    end
    check("t4_empty", level, 0);

    // 5: random backpressure over 100 commits, scoreboard model
    flush();
    check("t5_clr_ovf", ovf, 0);
    check("t5_clr_drop", drop_cnt, 0);
    seq_exp = 16'd0;
    n = 0;
    cyc = 0;
    stall = 1'b0;
    prev = '0;
    while ((n < 100 || q.size() != 0) && cyc < 2000) begin
      check("t5_valid", tif.trace_valid, 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("t5_seq", tif.trace_seq, q[0].seq);
        check("t5_pc", tif.trace_pc, q[0].pc);
        check("t5_wdata", tif.trace_wdata, q[0].wdata);
      end
      if (stall) begin
        check("t5_stable_seq", tif.trace_seq, prev.seq);
        check("t5_stable_pc", tif.trace_pc, prev.pc);
        check("t5_stable_wdata", tif.trace_wdata, prev.wdata);
      end
      r = ($urandom_range(0, 3) != 0) || (q.size() >= 12);
      c = (cyc % 2 == 0) && (n < 100);
      if (c) commit(32'h8000_0000 + 32'(4 * n), 4'hF, 5'((n % 31) + 1), $urandom);
      else idle();
      tif.trace_ready = r;
      stall = (q.size() != 0) && !r;
      if (q.size() != 0) prev = q[0];
      tick();
      if (r && q.size() != 0) q.delete(0);
      if (c) begin
        q.push_back('{seq: seq_exp, pc: tif.debug_wb_pc, wdata: tif.debug_wb_rf_wdata});
        seq_exp++;
        n++;
      end
      cyc++;
    end
    idle();
    check("t5_all_commits", 64'(n), 100);
    check("t5_done_valid", tif.trace_valid, 0);
    check("t5_ovf", ovf, 0);
    check("t5_drop", drop_cnt, 0);

    // 6: clr beats a same-cycle commit; async reset mid-drain
    flush();
    tif.trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      commit(32'h400 + 32'(4 * i), 4'hF, 5'd2, 32'(i));
      tick();
    end
    check("t6_level5", level, 5);
    commit(32'h500, 4'hF, 5'd2, 32'h5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    idle();
    check("t6_clr_level", level, 0);
    check("t6_clr_valid", tif.trace_valid, 0);
    check("t6_clr_ovf", ovf, 0);
    commit(32'h600, 4'hF, 5'd6, 32'h6);
    tick();
    check("t6_seq0", tif.trace_seq, 0);
    for (int i = 0; i < 3; i++) begin
      commit(32'h700 + 32'(4 * i), 4'hF, 5'd8, 32'(i));
      tick();
    end
    idle();
    tif.trace_ready = 1'b1;
    tick();
    check("t6_mid_valid", tif.trace_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", tif.trace_valid, 0);
    check("t6_async_level", level, 0);
    check("t6_async_seq", tif.trace_seq, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_post_level", level, 0);
    commit(32'h800, 4'hF, 5'd1, 32'h8);
    tick();
    idle();
    check("t6_post_seq", tif.trace_seq, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
